// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer pair and sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             write_en;
  logic             read_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] out;
  logic             mem_full;
  logic             mem_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_en, read_en, data_in,
    input  out, mem_full, mem_empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_en, read_en, data_in,
    output out, mem_full, mem_empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy, programmable thresholds and over/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle registered read.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    write_ptr;
  logic [AW-1:0]    read_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full_c;
  logic             empty_c;
  logic             rd_acc_c;
  logic             wr_acc_c;

  assign full_c   = (count_q == FULL_CNT);
  assign empty_c  = (count_q == '0);
  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign rd_acc_c = bus.read_en && !empty_c;
  assign wr_acc_c = bus.write_en && (!full_c || rd_acc_c);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[write_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_ptr   <= '0;
      read_ptr    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        write_ptr <= write_ptr + AW'(1);
      end
      if (rd_acc_c) begin
        read_ptr <= read_ptr + AW'(1);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q  <= bus.write_en && !wr_acc_c;
      underflow_q <= bus.read_en && !rd_acc_c;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; zero while empty so stale storage never leaks out.
  assign bus.out = empty_c ? '0 : mem[read_ptr];
`else
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else if (rd_acc_c) begin
      out_q <= mem[read_ptr];
    end
  end

  assign bus.out = out_q;
`endif

  assign bus.count        = count_q;
  assign bus.mem_full     = full_c;
  assign bus.mem_empty    = empty_c;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DEPTH=16, WIDTH=8); handles both read modes.
module tb_sync_fifo_param;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF_LEVEL = DEPTH - 2;
  localparam int unsigned AE_LEVEL = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_out;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = sb.size();
    check({tag, ".count"},        32'(bus.count), 32'(n));
    check({tag, ".mem_full"},     32'(bus.mem_full), 32'(n == int'(DEPTH)));
    check({tag, ".mem_empty"},    32'(bus.mem_empty), 32'(n == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full), 32'(n >= int'(AF_LEVEL)));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= int'(AE_LEVEL)));
  endtask

  // One clock of traffic: drive at negedge, predict from the queue, check after posedge.
  task automatic do_cycle(input logic we, input logic re, input logic [WIDTH-1:0] din);
    int n;
    logic racc, wacc;
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_in  = din;
    n    = sb.size();
    racc = re && (n > 0);
    wacc = we && ((n < int'(DEPTH)) || racc);
`ifdef SYNC_FIFO_FWFT_EN
    #1 check("fwft_head", 32'(bus.out), (n > 0) ? 32'(sb[0]) : 32'd0);
`endif
    @(posedge clk);
    #1;
    if (racc) begin
      exp = sb.pop_front();
      last_out = exp;
`ifndef SYNC_FIFO_FWFT_EN
      check("rd_data", 32'(bus.out), 32'(exp));
`endif
    end else begin
`ifndef SYNC_FIFO_FWFT_EN
      check("out_hold", 32'(bus.out), 32'(last_out));
`endif
    end
    if (wacc) sb.push_back(din);
    check("overflow",  32'(bus.overflow),  32'(we && !wacc));
    check("underflow", 32'(bus.underflow), 32'(re && !racc));
    check_flags("cyc");
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;
    reset = 1'b0;
    #1;
    sb.delete();
    last_out = '0;
    check("rst.out", 32'(bus.out), 32'd0);
    check("rst.overflow", 32'(bus.overflow), 32'd0);
    check("rst.underflow", 32'(bus.underflow), 32'd0);
    check_flags("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_out = '0;
    reset = 1'b1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;
    #2 reset = 1'b0;
    #20;
    apply_reset();

    // Fill to 15, then to full.
    for (int i = 0; i < 15; i++) do_cycle(1'b1, 1'b0, WIDTH'(8'h11 + i));
    check("fill15.af", 32'(bus.almost_full), 32'd1);
    check("fill15.full", 32'(bus.mem_full), 32'd0);
    do_cycle(1'b1, 1'b0, 8'h20);
    check("fill16.full", 32'(bus.mem_full), 32'd1);

    // Rejected write, then the pulse must drop.
    do_cycle(1'b1, 1'b0, 8'hAA);
    check("ovf.pulse", 32'(bus.overflow), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00);

    // Simultaneous access on full: both accepted.
    do_cycle(1'b1, 1'b1, 8'h55);
    check("full_rw.count", 32'(bus.count), 32'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) do_cycle(1'b0, 1'b1, 8'h00);
    check("drain.last", 32'(last_out), 32'h55);
`ifndef SYNC_FIFO_FWFT_EN
    check("drain.out", 32'(bus.out), 32'h55);
`endif

    // Underflow on empty, with and without a paired write.
    do_cycle(1'b0, 1'b1, 8'h00);
    check("udf.pulse", 32'(bus.underflow), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b1, 8'h33);
    check("empty_rw.count", 32'(bus.count), 32'd1);
    do_cycle(1'b0, 1'b1, 8'h00);
    check("empty_rw.data", 32'(last_out), 32'h33);

    // Interleaved pairs wrap the pointers more than twice.
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 1'b0, WIDTH'(8'h40 + i));
      do_cycle(1'b0, 1'b1, 8'h00);
    end

    // Random mix across all occupancy levels.
    for (int i = 0; i < 300; i++)
      do_cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)), WIDTH'($urandom));

    // Asynchronous reset mid-stream at count 7.
    apply_reset();
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, WIDTH'(8'hC0 + i));
    check("pre_rst.count", 32'(bus.count), 32'd7);
    apply_reset();
    do_cycle(1'b1, 1'b0, 8'h77);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_visible", 32'(bus.out), 32'h77);
`endif
    do_cycle(1'b0, 1'b1, 8'h00);
    check("post_rst.data", 32'(last_out), 32'h77);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_rst.out", 32'(bus.out), 32'h77);
`endif
    do_cycle(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
